// File: rtl/codec_sample_driver_if.sv
// codec_sample_driver_if: sample-request handshake plus 3-wire DAC link seen by codec_sample_driver.
interface codec_sample_driver_if;
  logic        generate_next;
  logic        sample_ready;
  logic [15:0] sample;
  logic        dac_sclk;
  logic        dac_sdata;
  logic        dac_frame;
  logic [7:0]  underrun_count;
  modport master (
    output generate_next, dac_sclk, dac_sdata, dac_frame, underrun_count,
    input  sample_ready, sample
  );
  modport slave (
    input  generate_next, dac_sclk, dac_sdata, dac_frame, underrun_count,
    output sample_ready, sample
  );
endinterface

// File: rtl/codec_sample_driver.sv
// codec_sample_driver: requests one sample per frame and shifts it MSB-first to a DAC at a fixed frame offset.
// Define CODEC_SAMPLE_OFFSET_BINARY_EN to send offset binary instead of two's complement.
module codec_sample_driver #(
  parameter int FRAME_LEN = 64,
  parameter int TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  codec_sample_driver_if.master bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] C_TO   = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_LD   = CW'(TIMEOUT + 2);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);
  typedef enum logic [2:0] {REQ, WAIT, HOLD, SHIFT, IDLE} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_held, r_sr, w_word;
  logic [4:0]    r_bc;
  logic [7:0]    r_under;
  logic          w_latch, w_miss, w_load;
`ifdef CODEC_SAMPLE_OFFSET_BINARY_EN
  assign w_word = {~r_held[15], r_held[14:0]};
`else
  assign w_word = r_held;
`endif
  always_ff @(posedge clk)
    if (!reset) r_state <= REQ;
    else        r_state <= w_next;
  // the frame counter wrap overrides every state, so a frame can never run long
  always_comb begin
    w_latch = r_state == WAIT && bus.sample_ready;
    w_miss  = r_state == WAIT && !bus.sample_ready && r_cnt == C_TO;
    w_load  = r_state == HOLD && r_cnt == C_LD;
    w_next  = r_cnt == C_LAST                                            ? REQ   :
              r_state == REQ                                             ? WAIT  :
              r_state == WAIT && (bus.sample_ready || r_cnt == C_TO)     ? HOLD  :
              w_load                                                     ? SHIFT :
              r_state == SHIFT && r_bc == 5'd31                          ? IDLE  :
                                                                           r_state;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      r_cnt   <= '0;
      r_held  <= '0;
      r_sr    <= '0;
      r_bc    <= '0;
      r_under <= '0;
    end else begin
      r_cnt <= r_cnt == C_LAST ? '0 : r_cnt + CW'(1);
      if (w_latch) r_held <= bus.sample;
      if (w_miss && r_under != 8'hFF) r_under <= r_under + 8'd1;
      if (w_load) begin
        r_sr <= w_word;
        r_bc <= '0;
      end else if (r_state == SHIFT) begin
        r_bc <= r_bc + 5'd1;
        if (r_bc[0]) r_sr <= {r_sr[14:0], 1'b0};
      end
    end
  // request is gated by reset so nothing toggles while reset is held
  assign bus.generate_next  = reset && r_state == REQ;
  assign bus.dac_frame      = w_load;
  assign bus.dac_sclk       = r_state == SHIFT && r_bc[0];
  assign bus.dac_sdata      = r_state == SHIFT && r_sr[15];
  assign bus.underrun_count = r_under;
endmodule

// File: doc/codec_sample_driver.md
# codec_sample_driver

Consumer end of the sample-request handshake used by the sine/note readers. Issues a one-cycle `generate_next` request once per audio frame and accepts the returned 16-bit `sample` on `sample_ready`. Serializes the sample MSB-first onto a 3-wire DAC link at a fixed, deterministic offset in the frame. Sits between the sample generator chain and the board codec pins.

## Interface
- `FRAME_LEN`, 64: clocks per audio frame; must be ≥ `TIMEOUT`+35.
- `TIMEOUT`, 16: maximum clocks to wait for `sample_ready` after a request; ≥ 1.

- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `generate_next`  out  1  one-cycle request pulse to the sample source.
- `sample_ready`  in  1  source strobe; `sample` is valid in the same cycle.
- `sample`  in  16  two's-complement sample from the source.
- `dac_sclk`  out  1  serial bit clock, clk/2 while shifting, else 0.
- `dac_sdata`  out  1  serial data, MSB first, changes only while `dac_sclk` is 0.
- `dac_frame`  out  1  one-cycle frame-sync pulse preceding bit 15.
- `underrun_count`  out  8  saturating count of frames with no sample received.

## Operation
- Frame counter `cnt` runs 0..FRAME_LEN-1 and wraps; all activity is keyed to `cnt`.
- FSM states: REQ, WAIT, HOLD, SHIFT.
  - REQ (`cnt`=0): `generate_next`=1 for exactly this cycle. Go to WAIT.
  - WAIT (`cnt`=1..TIMEOUT): on the first cycle with `sample_ready`=1, latch `sample` into `held`, then go to HOLD. If `cnt`=TIMEOUT passes with no strobe, keep the previous `held` (repeat the last sample), increment `underrun_count` (saturate at 255), then go to HOLD.
  - HOLD: idle until `cnt`=TIMEOUT+2. Copy `held` into shift register `sr`, pulse `dac_frame`, then go to SHIFT.
  - SHIFT: 32 cycles, two per bit.
    - Even phase: `dac_sclk`=0, `dac_sdata`=`sr[15]`.
    - Odd phase: `dac_sclk`=1, same data.
    - After the odd phase, shift `sr` left by one.
    - After bit 0, go to an idle state with outputs 0 until `cnt` wraps to REQ.
- The sink accepts only one sample per frame. `sample_ready` outside WAIT is ignored, including:
  - a strobe in the REQ cycle;
  - a strobe after a timeout;
  - a second strobe in the same WAIT.
- A late sample is never shifted out in the following frame.

## Timing
- Reset values: `generate_next`=0, `dac_sclk`=0, `dac_sdata`=0, `dac_frame`=0, `underrun_count`=0. Also `cnt`=0, `held`=0, `sr`=0.
- After reset, the first cycle with `reset`=1 is `cnt`=0, so `generate_next` is 1 in that cycle.
- If `reset` is asserted mid-frame, the next edge aborts the frame. No partial bits continue.
- With `cnt` referenced to the REQ cycle:
  - `dac_frame` is high at `cnt`=TIMEOUT+2.
  - Bit 15 occupies `cnt`=TIMEOUT+3..TIMEOUT+4.
  - Bit 0 ends at `cnt`=TIMEOUT+34.
- The shift start is independent of when `sample_ready` arrived, so output jitter is zero.
- Request-to-request period is exactly FRAME_LEN clocks.
- `sample_ready` may arrive at `cnt`=1 at the earliest (zero-latency source). It is latched on that edge.

## Configuration
- `CODEC_SAMPLE_OFFSET_BINARY_EN`:
  - Defined: `held[15]` is inverted when it is copied into `sr`, so the DAC receives offset binary (0x0000 → 0x8000, 0x8000 → 0x0000).
  - Undefined: the two's-complement value is shifted out unchanged.
- The latch and underrun logic are identical in both builds.

## Test plan
- Reset low for 3 cycles, then high. Required:
  - `generate_next`=1 in the first cycle after release and again exactly 64 cycles later;
  - all outputs 0 during reset.
- Source strobes `sample_ready` at `cnt`=3 with 0xA5C3. Required:
  - `dac_frame` at `cnt`=18;
  - `dac_sdata` sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, each bit held 2 cycles with `dac_sclk` 0 then 1;
  - `underrun_count` stays 0.
- Frame 1 delivers 0x1234; frame 2 has no strobe. Required:
  - frame 2 shifts 0x1234 again;
  - `underrun_count` becomes 1 at `cnt`=17 of frame 2.
- Strobe at `cnt`=0 and at `cnt`=20, with no strobe inside WAIT. Required: both ignored and underrun increments. Then a strobe at `cnt`=1 with 0x7FFF is latched, and 0x7FFF is shifted.
- 300 consecutive frames with no strobe. Required: `underrun_count` saturates at 255 without wrapping.
- Build with `CODEC_SAMPLE_OFFSET_BINARY_EN`, sample 0x0000. Required: shifted word is 0x8000.
- Assert `reset` low at `cnt`=25, mid-shift. Required: `dac_sclk` and `dac_sdata` are 0 on the next edge; after release, `generate_next` is high in the first cycle.
